// File: rtl/exp7_mostra_sequencia_pkg.sv
// Shared definitions for the sequence playback unit: state codes, the
// address/data width defaults that the RAM and control unit also use, and
// the timer width helper.
package exp7_mostra_sequencia_pkg;

    localparam int ADDR_W_PADRAO = 4;
    localparam int DATA_W_PADRAO = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LE      = 3'd1,
        ST_CAPTURA = 3'd2,
        ST_ACESO   = 3'd3,
        ST_APAGADO = 3'd4,
        ST_FIM     = 3'd5
    } estado_t;

    // The timer only ever holds T-1, so ceil(log2(max(T_ON,T_OFF))) bits are
    // enough; never narrower than one bit.
    function automatic int largura_temporizador(input int t_on, input int t_off);
        int maior;
        int w;
        maior = (t_on > t_off) ? t_on : t_off;
        w     = $clog2(maior);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/exp7_mostra_sequencia_temporizador.sv
// Loadable down-counter used to time the lit and dark slots of each move.
// It stops at zero rather than wrapping.
module exp7_temporizador #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    input  logic         conta,
    output logic         zero
);

    logic [W-1:0] r_contagem;

    // Load has priority over counting; counting saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (carrega) begin
            r_contagem <= valor;
        end else if (conta && (r_contagem != '0)) begin
            r_contagem <= r_contagem - 1'b1;
        end
    end

    assign zero = (r_contagem == '0);

endmodule

// File: rtl/exp7_mostra_sequencia.sv
// Sequence playback unit: reads moves 0..rodada from the synchronous
// sequence RAM and shows each one on the LEDs for T_ON cycles followed by
// T_OFF dark cycles, then pulses fim.
module exp7_mostra_sequencia
    import exp7_mostra_sequencia_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_ram,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              fim,
    output logic [2:0]        db_estado
);

    localparam int            TW          = largura_temporizador(T_ON, T_OFF);
    localparam logic [TW-1:0] CARGA_ACESO = TW'(T_ON - 1);
    localparam logic [TW-1:0] CARGA_APAGA = TW'(T_OFF - 1);

    estado_t           r_estado;
    estado_t           w_proximo;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_ultimo;
    logic [DATA_W-1:0] r_leds;
    logic              w_zero;
    logic              w_carrega;
    logic              w_conta;
    logic [TW-1:0]     w_valor;
    logic              w_ultimo_endereco;
    logic              w_inicio;

    assign w_ultimo_endereco = (r_endereco == r_ultimo);
    assign w_inicio          = (r_estado == ST_IDLE) && iniciar;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic; parar overrides everything, unused codes recover to IDLE.
    always_comb begin
        w_proximo = r_estado;
        if (parar) begin
            w_proximo = ST_IDLE;
        end else begin
            case (r_estado)
                ST_IDLE:    if (iniciar) w_proximo = ST_LE;
                ST_LE:      w_proximo = ST_CAPTURA;
                ST_CAPTURA: w_proximo = ST_ACESO;
                ST_ACESO:   if (w_zero) w_proximo = ST_APAGADO;
                ST_APAGADO: begin
                    if (w_zero) begin
                        w_proximo = w_ultimo_endereco ? ST_FIM : ST_LE;
                    end
                end
                ST_FIM:     w_proximo = ST_IDLE;
                default:    w_proximo = ST_IDLE;
            endcase
        end
    end

    // Timer control: load the lit time on capture, the dark time when the lit
    // time runs out, and clear it on abort.
    always_comb begin
        w_carrega = 1'b0;
        w_valor   = '0;
        w_conta   = 1'b0;
        if (parar) begin
            w_carrega = 1'b1;
        end else begin
            case (r_estado)
                ST_CAPTURA: begin
                    w_carrega = 1'b1;
                    w_valor   = CARGA_ACESO;
                end
                ST_ACESO: begin
                    w_conta = 1'b1;
                    if (w_zero) begin
                        w_carrega = 1'b1;
                        w_valor   = CARGA_APAGA;
                    end
                end
                ST_APAGADO: w_conta = 1'b1;
                default: ;
            endcase
        end
    end

    exp7_temporizador #(
        .W (TW)
    ) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (w_carrega),
        .valor   (w_valor),
        .conta   (w_conta),
        .zero    (w_zero)
    );

    // Read address and last-address latch; the end comparison happens before
    // any increment, so the address never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_endereco <= '0;
            r_ultimo   <= '0;
        end else if (parar) begin
            r_endereco <= '0;
        end else if (w_inicio) begin
            r_endereco <= '0;
            r_ultimo   <= rodada;
        end else if ((r_estado == ST_APAGADO) && w_zero && !w_ultimo_endereco) begin
            r_endereco <= r_endereco + 1'b1;
        end
    end

    // LED register: latch the RAM word on capture, go dark when the lit time ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else if (parar) begin
            r_leds <= '0;
        end else if (r_estado == ST_CAPTURA) begin
            r_leds <= dado_ram;
        end else if ((r_estado == ST_ACESO) && w_zero) begin
            r_leds <= '0;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        ocupado   = (r_estado != ST_IDLE);
        fim       = (r_estado == ST_FIM);
        db_estado = r_estado;
    end

    assign endereco = r_endereco;
    assign leds     = r_leds;

endmodule

// File: tb/tb_exp7_mostra_sequencia.sv
// Bench for exp7_mostra_sequencia: the stimulus side pushes one expected
// output sample per cycle of each run, the monitor pops and compares on
// every falling edge.
module tb_exp7_mostra_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;
    localparam int SLOT   = T_ON + T_OFF + 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar;
    logic              parar;
    logic [ADDR_W-1:0] rodada;
    logic [DATA_W-1:0] dado_ram;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              fim;
    logic [2:0]        db_estado;

    logic [DATA_W-1:0] mem [16];

    typedef struct packed {
        logic [ADDR_W-1:0] endereco;
        logic [DATA_W-1:0] leds;
        logic              ocupado;
        logic              fim;
        logic [2:0]        estado;
    } amostra_t;

    amostra_t fila[$];
    amostra_t esp_m;
    string    nome_teste = "inicio";
    int       ciclo = 0;
    int       checks = 0;
    int       errors = 0;

    always #5 clock = ~clock;

    // Synchronous RAM model: data valid one cycle after the address.
    always @(posedge clock) dado_ram <= mem[endereco];

    exp7_mostra_sequencia #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .rodada    (rodada),
        .dado_ram  (dado_ram),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .fim       (fim),
        .db_estado (db_estado)
    );

    task automatic compara(input string campo, input int obtido, input int esperado_v);
        checks++;
        if (obtido != esperado_v) begin
            errors++;
            $display("FAIL %s ciclo %0d %s: obtido %0d esperado %0d",
                     nome_teste, ciclo, campo, obtido, esperado_v);
        end
    endtask

    // Monitor: one expected sample per cycle while the queue holds any.
    always @(negedge clock) begin
        if (fila.size() > 0) begin
            esp_m = fila.pop_front();
            ciclo++;
            compara("endereco",  int'(endereco),  int'(esp_m.endereco));
            compara("leds",      int'(leds),      int'(esp_m.leds));
            compara("ocupado",   int'(ocupado),   int'(esp_m.ocupado));
            compara("fim",       int'(fim),       int'(esp_m.fim));
            compara("db_estado", int'(db_estado), int'(esp_m.estado));
        end
    end

    // Hand timeline: cycle c after the iniciar edge; each move is LE, CAPTURA,
    // T_ON lit cycles, T_OFF dark cycles; then one FIM cycle. From cycle
    // 'corte' on (if nonzero) everything is back at its reset value.
    function automatic amostra_t esperado(input int c, input int n, input int corte);
        amostra_t s;
        int m;
        int p;
        s = '0;
        if (corte > 0 && c >= corte) return s;
        if (c <= n * SLOT) begin
            m = (c - 1) / SLOT;
            p = (c - 1) % SLOT;
            s.endereco = ADDR_W'(m);
            s.ocupado  = 1'b1;
            if (p == 0)             s.estado = 3'd1;
            else if (p == 1)        s.estado = 3'd2;
            else if (p < 2 + T_ON) begin
                s.estado = 3'd3;
                s.leds   = mem[m];
            end else                s.estado = 3'd4;
        end else if (c == n * SLOT + 1) begin
            s.endereco = ADDR_W'(n - 1);
            s.ocupado  = 1'b1;
            s.fim      = 1'b1;
            s.estado   = 3'd5;
        end else begin
            s.endereco = ADDR_W'(n - 1);
        end
        return s;
    endfunction

    // Queue the whole expected run and pulse iniciar so it is sampled at edge 0.
    // Returns just after edge 0, i.e. early in cycle 1.
    task automatic inicia(input string nome, input int r, input int corte);
        int n;
        int total;
        n     = r + 1;
        total = (corte > 0) ? corte + 2 : n * SLOT + 2;
        @(negedge clock);
        #1;
        nome_teste = nome;
        ciclo      = 0;
        for (int c = 1; c <= total; c++) fila.push_back(esperado(c, n, corte));
        rodada  = ADDR_W'(r);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
    endtask

    // Move from early cycle 1 to early cycle k.
    task automatic vai_ciclo(input int k);
        repeat (k - 1) @(posedge clock);
        #1;
    endtask

    task automatic aguarda();
        for (int i = 0; i < 400; i++) begin
            if (fila.size() == 0) break;
            @(posedge clock);
        end
        checks++;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: restam %0d amostras esperado 0", nome_teste, fila.size());
            fila.delete();
        end
        $display("run %s: %0d cycles checked", nome_teste, ciclo);
    endtask

    task automatic carrega_124();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 4'd1;
        mem[1] = 4'd2;
        mem[2] = 4'd4;
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        parar   = 1'b0;
        rodada  = '0;
        carrega_124();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset: everything zero for 10 cycles.
        @(negedge clock);
        #1;
        nome_teste = "ocioso";
        ciclo      = 0;
        for (int i = 0; i < 10; i++) fila.push_back('0);
        aguarda();

        // Three moves 1,2,4.
        inicia("rodada2", 2, 0);
        aguarda();

        // Single move.
        mem[0] = 4'd8;
        inicia("rodada0", 0, 0);
        aguarda();

        // Full address range, including a zero-valued move at address 0.
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
        inicia("rodada15", 15, 0);
        aguarda();

        // Abort during cycle 12, then replay from address 0.
        carrega_124();
        inicia("parar", 2, 13);
        vai_ciclo(12);
        parar = 1'b1;
        @(posedge clock);
        #1;
        parar = 1'b0;
        aguarda();
        inicia("replay", 2, 0);
        aguarda();

        // iniciar re-pulsed mid-run is ignored.
        inicia("reiniciar", 2, 0);
        vai_ciclo(5);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        aguarda();

        // rodada changed mid-run: the latched value still governs.
        inicia("troca_rodada", 2, 0);
        vai_ciclo(4);
        rodada = '0;
        aguarda();

        // Asynchronous reset during cycle 10 clears outputs before the next edge.
        inicia("reset_meio", 2, 10);
        vai_ciclo(10);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        aguarda();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
